// File: rtl/nco_sweep_pkg.sv
// Shared types and default widths for the NCO sweep controller slice.
package nco_sweep_pkg;

    localparam int APR_W = 32;
    localparam int NSW_W = 16;
    localparam int DWW_W = 24;

    localparam logic [APR_W-1:0] ZERO_INC = {APR_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// Control, configuration and tone-output bundle between a sweep master and the controller.
interface nco_sweep_ctrl_if #(
    parameter int APR = nco_sweep_pkg::APR_W,
    parameter int NSW = nco_sweep_pkg::NSW_W,
    parameter int DWW = nco_sweep_pkg::DWW_W
);
    logic           clken;
    logic           start;
    logic           abort;
    logic [APR-1:0] cfg_start_inc;
    logic [APR-1:0] cfg_step;
    logic [NSW-1:0] cfg_num_steps;
    logic [DWW-1:0] cfg_dwell;
    logic           cfg_repeat;
    logic [APR-1:0] phi_inc_o;
    logic           busy;
    logic           step_strobe;
    logic           sweep_done;

    modport master (
        output clken, start, abort, cfg_start_inc, cfg_step, cfg_num_steps, cfg_dwell, cfg_repeat,
        input  phi_inc_o, busy, step_strobe, sweep_done
    );

    modport slave (
        input  clken, start, abort, cfg_start_inc, cfg_step, cfg_num_steps, cfg_dwell, cfg_repeat,
        output phi_inc_o, busy, step_strobe, sweep_done
    );
endinterface

// File: rtl/nco_sweep_dwell_timer.sv
// Loadable down-counter that times how long each tone is held; flags zero when the dwell expires.
module nco_sweep_dwell_timer #(
    parameter int DWW = nco_sweep_pkg::DWW_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clken_i,
    input  logic           load_i,
    input  logic [DWW-1:0] load_val_i,
    output logic           zero_o
);
    logic [DWW-1:0] cnt_q;
    logic [DWW-1:0] cnt_d;

    // Next count: load has priority, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (clken_i) begin
            if (load_i) begin
                cnt_d = load_val_i;
            end else if (cnt_q != {DWW{1'b0}}) begin
                cnt_d = cnt_q - {{(DWW-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {DWW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {DWW{1'b0}});
endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped linear chirp generator: drives the NCO phase increment through a shadowed sweep
// configuration with per-tone dwell, optional auto-repeat and abort.
module nco_sweep_ctrl #(
    parameter int APR = nco_sweep_pkg::APR_W,
    parameter int NSW = nco_sweep_pkg::NSW_W,
    parameter int DWW = nco_sweep_pkg::DWW_W
) (
    input  logic             clk,
    input  logic             reset,
    nco_sweep_ctrl_if.slave  bus
);
    import nco_sweep_pkg::*;

    sweep_state_e   state_q, state_d;
    logic [APR-1:0] phi_q, phi_d;
    logic           busy_q, busy_d;
    logic           strobe_q, strobe_d;
    logic           done_q, done_d;
    logic [NSW-1:0] step_cnt_q, step_cnt_d;
    logic [APR-1:0] sh_start_q, sh_start_d;
    logic [APR-1:0] sh_step_q, sh_step_d;
    logic [NSW-1:0] sh_num_q, sh_num_d;
    logic [DWW-1:0] sh_dwell_q, sh_dwell_d;
    logic           sh_rep_q, sh_rep_d;

    logic           tmr_load_s;
    logic [DWW-1:0] tmr_val_s;
    logic           tmr_zero_s;
    logic           start_ok_s;
    logic           last_tone_s;

    // In IDLE an abort alongside start wins, so the request is dropped
    assign start_ok_s  = bus.clken & bus.start & ~bus.abort;
    assign last_tone_s = tmr_zero_s & (step_cnt_q == sh_num_q);

    nco_sweep_dwell_timer #(.DWW(DWW)) u_dwell_timer (
        .clk        (clk),
        .reset      (reset),
        .clken_i    (bus.clken),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .zero_o     (tmr_zero_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; every transition waits for clken
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) state_d = ST_DWELL;
                else            state_d = ST_IDLE;
            end
            ST_DWELL: begin
                if (!bus.clken)       state_d = ST_DWELL;
                else if (bus.abort)   state_d = ST_IDLE;
                else if (last_tone_s) state_d = ST_DONE;
                else                  state_d = ST_DWELL;
            end
            ST_DONE: begin
                if (!bus.clken)     state_d = ST_DONE;
                else if (bus.abort) state_d = ST_IDLE;
                else if (sh_rep_q)  state_d = ST_DWELL;
                else                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; pulses default low so a held clken never repeats them
    always_comb begin
        phi_d      = phi_q;
        busy_d     = busy_q;
        strobe_d   = 1'b0;
        done_d     = 1'b0;
        step_cnt_d = step_cnt_q;
        sh_start_d = sh_start_q;
        sh_step_d  = sh_step_q;
        sh_num_d   = sh_num_q;
        sh_dwell_d = sh_dwell_q;
        sh_rep_d   = sh_rep_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = sh_dwell_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    sh_start_d = bus.cfg_start_inc;
                    sh_step_d  = bus.cfg_step;
                    sh_num_d   = bus.cfg_num_steps;
                    sh_dwell_d = bus.cfg_dwell;
                    sh_rep_d   = bus.cfg_repeat;
                    phi_d      = bus.cfg_start_inc;
                    busy_d     = 1'b1;
                    strobe_d   = 1'b1;
                    step_cnt_d = {NSW{1'b0}};
                    tmr_load_s = 1'b1;
                    tmr_val_s  = bus.cfg_dwell;
                end else begin
                    phi_d = phi_q;
                end
            end
            ST_DWELL: begin
                if (!bus.clken) begin
                    phi_d = phi_q;
                end else if (bus.abort) begin
                    phi_d      = APR'(ZERO_INC);
                    busy_d     = 1'b0;
                    step_cnt_d = {NSW{1'b0}};
                    tmr_load_s = 1'b1;
                    tmr_val_s  = {DWW{1'b0}};
                end else if (tmr_zero_s && (step_cnt_q != sh_num_q)) begin
                    phi_d      = phi_q + sh_step_q;
                    step_cnt_d = step_cnt_q + {{(NSW-1){1'b0}}, 1'b1};
                    strobe_d   = 1'b1;
                    tmr_load_s = 1'b1;
                end else if (last_tone_s) begin
                    done_d = 1'b1;
                end else begin
                    phi_d = phi_q;
                end
            end
            ST_DONE: begin
                if (!bus.clken) begin
                    done_d = 1'b0;
                end else if (bus.abort) begin
                    phi_d      = APR'(ZERO_INC);
                    busy_d     = 1'b0;
                    step_cnt_d = {NSW{1'b0}};
                    tmr_load_s = 1'b1;
                    tmr_val_s  = {DWW{1'b0}};
                end else if (sh_rep_q) begin
                    phi_d      = sh_start_q;
                    strobe_d   = 1'b1;
                    step_cnt_d = {NSW{1'b0}};
                    tmr_load_s = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            default: begin
                phi_d  = APR'(ZERO_INC);
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath, shadow configuration and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            phi_q      <= APR'(ZERO_INC);
            busy_q     <= 1'b0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            step_cnt_q <= {NSW{1'b0}};
            sh_start_q <= {APR{1'b0}};
            sh_step_q  <= {APR{1'b0}};
            sh_num_q   <= {NSW{1'b0}};
            sh_dwell_q <= {DWW{1'b0}};
            sh_rep_q   <= 1'b0;
        end else begin
            phi_q      <= phi_d;
            busy_q     <= busy_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
            step_cnt_q <= step_cnt_d;
            sh_start_q <= sh_start_d;
            sh_step_q  <= sh_step_d;
            sh_num_q   <= sh_num_d;
            sh_dwell_q <= sh_dwell_d;
            sh_rep_q   <= sh_rep_d;
        end
    end

    assign bus.phi_inc_o   = phi_q;
    assign bus.busy        = busy_q;
    assign bus.step_strobe = strobe_q;
    assign bus.sweep_done  = done_q;
endmodule
